axis_rate_monitor: RTL and testbench

Passive AXI-Stream throughput meter that counts bytes and packets crossing a stream handshake over a programmable cycle window and publishes per-window snapshots. It taps the same master-stream handshake that the rate limiter drives, observing without asserting any stream signal. It gives software a measured rate to compare against the programmed limit.

---
 rtl/axis_rate_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_axis_rate_monitor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rate_monitor.sv
// axis_rate_monitor: passive AXI-Stream throughput meter.
// Counts bytes (popcount of tstrb) and packets (tlast beats) seen on a tapped
// stream handshake over a programmable window of interval_cycles clocks and
// publishes a snapshot with a one-cycle win_valid pulse at every window close.
//
// Optional feature: define RATE_MON_MAX_PKT_EN to track the largest packet
// (in bytes) whose tlast fell inside each window. Without the macro,
// win_max_pkt_bytes is constant 0.
//
// Handshake: a beat is a cycle where s_axis_tvalid and s_axis_tready are both
// high at the rising edge of axi_aclk. All tap inputs are observed only; this
// block drives nothing back onto the stream.
module axis_rate_monitor #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_S_AXI_DATA_WIDTH  = 32
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  input  logic                                 sw_rst,
  input  logic                                 mon_en,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        interval_cycles,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        win_bytes,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        win_pkts,
  output logic                                 win_sat,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        win_seq,
  output logic                                 win_valid,
  output logic [15:0]                          win_max_pkt_bytes,
  output logic                                 dbg_state
);

  localparam int SW  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int BW  = $clog2(SW + 1);
  localparam int AW  = C_S_AXI_DATA_WIDTH;
  localparam int AW1 = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_nx;
  logic            enable_ok;
  logic            active;
  logic            close;

  logic            beat;
  logic            pkt_inc;
  logic [BW-1:0]   strobe_bytes;
  logic [BW-1:0]   beat_bytes;

  logic [AW-1:0]   acc_bytes;
  logic [AW-1:0]   acc_pkts;
  logic            sat_q;
  logic [AW-1:0]   cyc;

  logic [AW:0]     bytes_sum;
  logic [AW-1:0]   bytes_next;
  logic [AW-1:0]   pkts_next;
  logic            sat_now;
  logic [15:0]     max_close;

  assign beat      = s_axis_tvalid & s_axis_tready;
  assign pkt_inc   = beat & s_axis_tlast;
  assign enable_ok = mon_en & (interval_cycles != '0);

  // Byte count of the current beat: popcount of the strobes, zero when no beat
  always_comb begin
    strobe_bytes = '0;
    for (int i = 0; i < SW; i++) begin
      strobe_bytes = strobe_bytes + BW'(s_axis_tstrb[i]);
    end
    beat_bytes = beat ? strobe_bytes : '0;
  end

  // FSM state register; sw_rst behaves like reset
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q <= ST_IDLE;
    end else if (sw_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // FSM next state: run only while enabled with a non-zero interval
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: if (enable_ok)  state_nx = ST_RUN;
      ST_RUN:  if (!enable_ok) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs: counting enable and window close strobe
  always_comb begin
    active    = (state_q == ST_RUN) && enable_ok;
    close     = active && (cyc >= (interval_cycles - AW'(1)));
    dbg_state = (state_q == ST_RUN);
  end

  // Saturating next values of the accumulators including this cycle's beat
  always_comb begin
    bytes_sum  = {1'b0, acc_bytes} + AW1'(beat_bytes);
    bytes_next = bytes_sum[AW] ? '1 : bytes_sum[AW-1:0];
    pkts_next  = (pkt_inc && (&acc_pkts)) ? acc_pkts : acc_pkts + AW'(pkt_inc);
    sat_now    = bytes_sum[AW] | (pkt_inc & (&acc_pkts));
  end

  // Window accumulators and cycle counter; cleared when idle or at a close
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      acc_bytes <= '0;
      acc_pkts  <= '0;
      sat_q     <= 1'b0;
      cyc       <= '0;
    end else if (sw_rst || !active || close) begin
      acc_bytes <= '0;
      acc_pkts  <= '0;
      sat_q     <= 1'b0;
      cyc       <= '0;
    end else begin
      acc_bytes <= bytes_next;
      acc_pkts  <= pkts_next;
      sat_q     <= sat_q | sat_now;
      cyc       <= cyc + AW'(1);
    end
  end

`ifdef RATE_MON_MAX_PKT_EN
  logic [15:0] pkt_len_q;
  logic [16:0] len_sum;
  logic [15:0] pkt_len_sum;
  logic [15:0] win_max_q;

  // Running length of the packet in flight and the window max including it
  always_comb begin
    len_sum     = {1'b0, pkt_len_q} + 17'(beat_bytes);
    pkt_len_sum = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    max_close   = win_max_q;
    if (pkt_inc && (pkt_len_sum > win_max_q)) max_close = pkt_len_sum;
  end

  // In-packet byte counter; only reset/sw_rst clear it, not enable changes
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      pkt_len_q <= '0;
    end else if (sw_rst) begin
      pkt_len_q <= '0;
    end else if (beat) begin
      pkt_len_q <= s_axis_tlast ? 16'd0 : pkt_len_sum;
    end
  end

  // Window max packet length; cleared together with the accumulators
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      win_max_q <= '0;
    end else if (sw_rst || !active || close) begin
      win_max_q <= '0;
    end else begin
      win_max_q <= max_close;
    end
  end
`else
  // Max-packet tracking not built: report zero
  always_comb begin
    max_close = 16'd0;
  end
`endif

  // Snapshot registers and the one-cycle win_valid pulse
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      win_bytes         <= '0;
      win_pkts          <= '0;
      win_sat           <= 1'b0;
      win_seq           <= '0;
      win_valid         <= 1'b0;
      win_max_pkt_bytes <= '0;
    end else if (sw_rst) begin
      win_bytes         <= '0;
      win_pkts          <= '0;
      win_sat           <= 1'b0;
      win_seq           <= '0;
      win_valid         <= 1'b0;
      win_max_pkt_bytes <= '0;
    end else begin
      win_valid <= close;
      if (close) begin
        win_bytes         <= bytes_next;
        win_pkts          <= pkts_next;
        win_sat           <= sat_q | sat_now;
        win_seq           <= win_seq + AW'(1);
        win_max_pkt_bytes <= max_close;
      end
    end
  end

endmodule

// File: tb/tb_axis_rate_monitor.sv
// tb_axis_rate_monitor: directed scoreboard bench for axis_rate_monitor.
// Stimulus pushes each expected window snapshot into a queue; a monitor pops
// and compares on every win_valid. A second instance with 8-bit counters
// exercises saturation.
module tb_axis_rate_monitor;

  localparam int DW  = 256;
  localparam int SW  = DW / 8;
  localparam int AW  = 32;
  localparam int AW8 = 8;
  localparam int EW  = 16 + 1 + 3 * AW;
  localparam int EW8 = 16 + 1 + 3 * AW8;
  localparam logic [SW-1:0] FULL = {SW{1'b1}};
  localparam logic [SW-1:0] HALF = 32'h0000FFFF;

  // ---------------- clock / reset ----------------
  logic clk;
  logic axi_areset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0]  s_axis_tstrb;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic           s_axis_tlast;
  logic           sw_rst;
  logic           mon_en;
  logic [AW-1:0]  interval_cycles;
  logic [AW-1:0]  win_bytes;
  logic [AW-1:0]  win_pkts;
  logic           win_sat;
  logic [AW-1:0]  win_seq;
  logic           win_valid;
  logic [15:0]    win_max_pkt_bytes;
  logic           dbg_state;

  logic           mon_en8;
  logic [AW8-1:0] interval8;
  logic [AW8-1:0] win_bytes8;
  logic [AW8-1:0] win_pkts8;
  logic           win_sat8;
  logic [AW8-1:0] win_seq8;
  logic           win_valid8;
  logic [15:0]    win_max8;
  logic           dbg_state8;

  axis_rate_monitor #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXI_DATA_WIDTH(AW)) dut (
    .axi_aclk(clk), .axi_areset(axi_areset),
    .s_axis_tstrb(s_axis_tstrb), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .sw_rst(sw_rst), .mon_en(mon_en), .interval_cycles(interval_cycles),
    .win_bytes(win_bytes), .win_pkts(win_pkts), .win_sat(win_sat),
    .win_seq(win_seq), .win_valid(win_valid),
    .win_max_pkt_bytes(win_max_pkt_bytes), .dbg_state(dbg_state)
  );

  axis_rate_monitor #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXI_DATA_WIDTH(AW8)) dut8 (
    .axi_aclk(clk), .axi_areset(axi_areset),
    .s_axis_tstrb(s_axis_tstrb), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .sw_rst(sw_rst), .mon_en(mon_en8), .interval_cycles(interval8),
    .win_bytes(win_bytes8), .win_pkts(win_pkts8), .win_sat(win_sat8),
    .win_seq(win_seq8), .win_valid(win_valid8),
    .win_max_pkt_bytes(win_max8), .dbg_state(dbg_state8)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [EW-1:0]  exp_q[$];
  logic [EW8-1:0] exp8_q[$];

  function automatic logic [15:0] mx(input logic [15:0] v);
`ifdef RATE_MON_MAX_PKT_EN
    return v;
`else
    return (v & 16'h0);
`endif
  endfunction

  task automatic expect_win(input logic [AW-1:0] b, input logic [AW-1:0] p,
                            input logic s, input logic [AW-1:0] q, input logic [15:0] m);
    exp_q.push_back({m, s, q, p, b});
  endtask

  task automatic expect_win8(input logic [AW8-1:0] b, input logic [AW8-1:0] p,
                             input logic s, input logic [AW8-1:0] q, input logic [15:0] m);
    exp8_q.push_back({m, s, q, p, b});
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    if (win_valid) begin
      logic [EW-1:0] e;
      logic [EW-1:0] g;
      n_vec++;
      g = {win_max_pkt_bytes, win_sat, win_seq, win_pkts, win_bytes};
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL snap_unexpected: got seq=%0d bytes=%0d expected no snapshot",
                 win_seq, win_bytes);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_miss++;
          $display("FAIL snap: got bytes=%0d pkts=%0d sat=%0d seq=%0d max=%0d expected bytes=%0d pkts=%0d sat=%0d seq=%0d max=%0d",
                   win_bytes, win_pkts, win_sat, win_seq, win_max_pkt_bytes,
                   e[AW-1:0], e[2*AW-1:AW], e[3*AW], e[3*AW-1:2*AW], e[EW-1:3*AW+1]);
        end
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (win_valid8) begin
      logic [EW8-1:0] e;
      logic [EW8-1:0] g;
      n_vec++;
      g = {win_max8, win_sat8, win_seq8, win_pkts8, win_bytes8};
      if (exp8_q.size() == 0) begin
        n_miss++;
        $display("FAIL snap8_unexpected: got seq=%0d bytes=%0d expected no snapshot",
                 win_seq8, win_bytes8);
      end else begin
        e = exp8_q.pop_front();
        if (g !== e) begin
          n_miss++;
          $display("FAIL snap8: got bytes=%0d pkts=%0d sat=%0d seq=%0d max=%0d expected bytes=%0d pkts=%0d sat=%0d seq=%0d max=%0d",
                   win_bytes8, win_pkts8, win_sat8, win_seq8, win_max8,
                   e[AW8-1:0], e[2*AW8-1:AW8], e[3*AW8], e[3*AW8-1:2*AW8], e[EW8-1:3*AW8+1]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic v, input logic r, input logic l, input logic [SW-1:0] s);
    s_axis_tvalid = v;
    s_axis_tready = r;
    s_axis_tlast  = l;
    s_axis_tstrb  = s;
  endtask

  task automatic send_pkt(input int len);
    int rem;
    int nb;
    logic [SW-1:0] m;
    rem = len;
    while (rem > 0) begin
      nb = (rem > SW) ? SW : rem;
      m  = '0;
      for (int j = 0; j < nb; j++) m[j] = 1'b1;
      tap(1'b1, 1'b1, rem <= SW, m);
      step();
      rem = rem - nb;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bytes"}, 64'(win_bytes), 64'd0);
    chk({tag, "_pkts"},  64'(win_pkts), 64'd0);
    chk({tag, "_sat"},   64'(win_sat), 64'd0);
    chk({tag, "_seq"},   64'(win_seq), 64'd0);
    chk({tag, "_valid"}, 64'(win_valid), 64'd0);
    chk({tag, "_max"},   64'(win_max_pkt_bytes), 64'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    axi_areset = 1'b1;
    sw_rst = 1'b0; mon_en = 1'b0; interval_cycles = '0;
    mon_en8 = 1'b0; interval8 = '0;
    tap(1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1 axi_areset = 1'b0;
    chk_zero("reset");
    chk("reset_state", 64'(dbg_state), 64'd0);
    repeat (3) step();

    // Continuous full beats, 4-beat packets, N=100
    interval_cycles = 100; mon_en = 1'b1;
    tap(1'b0, 1'b0, 1'b0, '0); step();
    expect_win(3200, 25, 1'b0, 1, mx(128));
    expect_win(3200, 25, 1'b0, 2, mx(128));
    expect_win(3200, 25, 1'b0, 3, mx(128));
    for (int i = 0; i < 300; i++) begin
      tap(1'b1, 1'b1, (i % 4) == 3, FULL); step();
    end
    mon_en = 1'b0; tap(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step();

    // tready at 50%; second window uses 16-byte tlast beats
    mon_en = 1'b1; step();
    expect_win(1600, 12, 1'b0, 4, mx(128));
    expect_win(1392, 13, 1'b0, 5, mx(112));
    for (int i = 0; i < 200; i++) begin
      int k;
      logic l;
      k = i / 2;
      l = (k % 4) == 3;
      tap(1'b1, (i % 2) == 0, l, (i >= 100 && l) ? HALF : FULL); step();
    end
    mon_en = 1'b0; tap(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step();

    // Interval 1000 reduced to 10 at cyc=500, then mon_en dropped at cyc=5
    interval_cycles = 1000; mon_en = 1'b1; step();
    expect_win(16032, 501, 1'b0, 6, mx(32));
    expect_win(320, 10, 1'b0, 7, mx(32));
    expect_win(320, 10, 1'b0, 8, mx(32));
    for (int i = 0; i < 526; i++) begin
      if (i == 500) interval_cycles = 10;
      tap(1'b1, 1'b1, 1'b1, FULL); step();
    end
    mon_en = 1'b0;
    repeat (15) step();
    chk("hold_seq", 64'(win_seq), 64'd8);
    chk("hold_bytes", 64'(win_bytes), 64'd320);
    chk("hold_pkts", 64'(win_pkts), 64'd10);
    chk("hold_valid", 64'(win_valid), 64'd0);
    tap(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step();

    // Saturation on the 8-bit instance, then a clean window
    interval8 = 20; mon_en8 = 1'b1; step();
    expect_win8(8'hFF, 5, 1'b1, 1, mx(128));
    expect_win8(64, 1, 1'b0, 2, mx(64));
    for (int i = 0; i < 20; i++) begin
      tap(1'b1, 1'b1, (i % 4) == 3, FULL); step();
    end
    for (int i = 0; i < 20; i++) begin
      if (i < 2) tap(1'b1, 1'b1, i == 1, FULL);
      else       tap(1'b0, 1'b0, 1'b0, '0);
      step();
    end
    mon_en8 = 1'b0; tap(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step();

    // Asynchronous reset mid-traffic, then a fresh N=100 window
    interval_cycles = 100; mon_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tap(1'b1, 1'b1, 1'b1, FULL); step();
    end
    #3 axi_areset = 1'b1;
    #1;
    chk_zero("async_rst");
    chk("async_rst_seq8", 64'(win_seq8), 64'd0);
    repeat (3) @(posedge clk);
    #1 axi_areset = 1'b0;
    expect_win(3200, 100, 1'b0, 1, mx(32));
    for (int i = 0; i < 101; i++) begin
      tap(1'b1, 1'b1, 1'b1, FULL); step();
    end
    mon_en = 1'b0; tap(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step();

    // N=1: per-cycle snapshots, then sw_rst on a closing cycle
    interval_cycles = 1; mon_en = 1'b1; step();
    expect_win(32, 1, 1'b0, 2, mx(32));
    expect_win(4, 0, 1'b0, 3, mx(0));
    expect_win(0, 0, 1'b0, 4, mx(0));
    tap(1'b1, 1'b1, 1'b1, FULL); step();
    tap(1'b1, 1'b1, 1'b0, 32'h0000000F); step();
    tap(1'b1, 1'b0, 1'b0, FULL); step();
    sw_rst = 1'b1; tap(1'b1, 1'b1, 1'b1, FULL); step();
    sw_rst = 1'b0; mon_en = 1'b0; tap(1'b0, 1'b0, 1'b0, '0);
    chk_zero("sw_rst");
    repeat (3) step();

    // Packets of 64, 1514 and 200 bytes in one 60-cycle window
    interval_cycles = 60; mon_en = 1'b1; step();
    expect_win(1778, 3, 1'b0, 1, mx(1514));
    send_pkt(64);
    send_pkt(1514);
    send_pkt(200);
    tap(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step();
    mon_en = 1'b0;
    repeat (5) step();

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("exp8_q_drained", 64'(exp8_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
